// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, hold-until-ack imem requests, prefetch FIFO of {npc, segment}.
// Latency: ack in cycle N gives seg_valid from cycle N+1; zero-wait memory streams one segment per cycle.
// Backpressure: seg_ready low fills the FIFO, then imem_req drops until a pop frees an entry.
// Ports: clk/rst_n; imem_req/imem_addr/imem_ack/imem_data to memory; redirect/redirect_pc from execute;
//        seg_valid/seg_ready/segment/npc to the first control stage.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  input  logic        seg_ready,
  output logic        seg_valid,
  output logic [15:0] segment,
  output logic [7:0]  npc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef struct packed {
    logic [7:0]  npc;
    logic [15:0] seg;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [7:0]      fetch_pc_q, fetch_pc_d;
  logic [7:0]      req_addr_q, req_addr_d;
  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  entry_t          hold_q;

  logic            pop, push, flush;
  logic [CW-1:0]   count_pop;
  logic [7:0]      addr_inc;
  entry_t          head;

  assign head      = mem_q[rd_ptr_q];
  assign seg_valid = (count_q != '0);
  assign imem_req  = (state_q != IDLE);
  assign imem_addr = req_addr_q;
  // When empty, keep presenting the last head so the outputs never glitch to stale slots.
  assign {npc, segment} = seg_valid ? head : hold_q;

  assign pop       = seg_valid & seg_ready;
  assign count_pop = count_q - {{(CW-1){1'b0}}, pop};
  assign addr_inc  = req_addr_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = REQ;
        end else if (count_pop < DEPTH_C) begin
          req_addr_d = fetch_pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          if (imem_ack) begin
            // Response for the old path is dropped; restart at the target immediately.
            req_addr_d = redirect_pc;
          end else begin
            // Address must stay put until the outstanding transaction completes.
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = addr_inc;
          // req_addr also advances when going IDLE so imem_addr shows the next fetch address.
          req_addr_d = addr_inc;
          if ((count_pop + ONE_C) >= DEPTH_C) begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end
        if (imem_ack) begin
          // Discarded response; a same-cycle redirect target takes precedence over fetch_pc.
          state_d    = REQ;
          req_addr_d = redirect ? redirect_pc : fetch_pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (seg_valid) begin
        hold_q <= head;
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= '{npc: addr_inc, seg: imem_data};
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        count_q <= count_pop + {{(CW-1){1'b0}}, push};
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        seg_ready;
  logic        seg_valid;
  logic [15:0] segment;
  logic [7:0]  npc;

  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] exp_q[$];

  // Memory model: ack after `lat` wait cycles while enabled, data = {addr, ~addr}.
  int   wcnt;
  int   ack_cnt;
  int   lat;
  logic ack_en;

  fetch_unit #(.DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .seg_ready  (seg_ready),
    .seg_valid  (seg_valid),
    .segment    (segment),
    .npc        (npc)
  );

  always #5 clk = ~clk;

  assign imem_ack  = imem_req && ack_en && (wcnt >= lat);
  assign imem_data = {imem_addr, ~imem_addr};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt    <= 0;
      ack_cnt <= 0;
    end else begin
      if (imem_req && !imem_ack) wcnt <= wcnt + 1;
      else                       wcnt <= 0;
      if (imem_req && imem_ack)  ack_cnt <= ack_cnt + 1;
    end
  end

  // Scoreboard monitor: every accepted segment is compared against the head of exp_q.
  always @(negedge clk) begin
    if (rst_n && seg_valid && seg_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL seg_unexpected: got npc=%h seg=%h, required no output", npc, segment);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({npc, segment} !== e) begin
          n_err++;
          $display("FAIL seg_data: got npc=%h seg=%h, required npc=%h seg=%h",
                   npc, segment, e[23:16], e[15:0]);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic use_redir, input logic [7:0] rpc);
    rst_n       = 1'b0;
    redirect    = use_redir;
    redirect_pc = rpc;
    exp_q.delete();
    step;
    step;
    rst_n = 1'b1;
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step;
    chk(nm, 32'(exp_q.size()), 32'd0);
    step;
    chk({nm, "_vld"}, 32'(seg_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    seg_ready   = 1'b0;
    lat         = 0;
    ack_en      = 1'b1;
    #3;
    chk("rst_req",  32'(imem_req),  32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h00);
    chk("rst_vld",  32'(seg_valid), 32'd0);
    chk("rst_seg",  32'(segment),   32'h0000);
    chk("rst_npc",  32'(npc),       32'h00);

    // Reset then stream with zero-wait memory.
    seg_ready = 1'b1;
    do_reset(1'b0, 8'h00);
    for (int a = 0; a < 10; a++) begin
      logic [7:0] av;
      av = 8'(a);
      exp_q.push_back({av + 8'd1, av, ~av});
    end
    step;
    chk("s1_req",  32'(imem_req),  32'd1);
    chk("s1_addr", 32'(imem_addr), 32'h00);
    chk("s1_vld",  32'(seg_valid), 32'd0);
    step;
    chk("s2_vld", 32'(seg_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step;
      chk("stream_vld",  32'(seg_valid), 32'd1);
      chk("stream_addr", 32'(imem_addr), 32'(2 + i));
    end

    // Backpressure with DEPTH=2.
    seg_ready = 1'b0;
    do_reset(1'b0, 8'h00);
    exp_q.push_back({8'h01, 16'h00FF});
    exp_q.push_back({8'h02, 16'h01FE});
    exp_q.push_back({8'h03, 16'h02FD});
    repeat (5) step;
    chk("bp_req",  32'(imem_req),  32'd0);
    chk("bp_addr", 32'(imem_addr), 32'h02);
    chk("bp_acks", 32'(ack_cnt),   32'd2);
    chk("bp_vld",  32'(seg_valid), 32'd1);
    seg_ready = 1'b1;
    step;
    chk("bp_rereq",  32'(imem_req),  32'd1);
    chk("bp_readdr", 32'(imem_addr), 32'h02);
    step;
    ack_en = 1'b0;
    chk("bp_acks3", 32'(ack_cnt), 32'd3);
    wait_empty("bp_drain");

    // Redirect while a request waits for a slow ack.
    lat = 3; ack_en = 1'b1; seg_ready = 1'b1;
    do_reset(1'b1, 8'h05);
    step;
    redirect = 1'b0;
    chk("ws_addr0", 32'(imem_addr), 32'h05);
    chk("ws_req0",  32'(imem_req),  32'd1);
    step;
    redirect = 1'b1; redirect_pc = 8'h40;
    step;
    redirect = 1'b0;
    chk("ws_addr1", 32'(imem_addr), 32'h05);
    chk("ws_req1",  32'(imem_req),  32'd1);
    chk("ws_noack", 32'(imem_ack),  32'd0);
    step;
    chk("ws_addr2", 32'(imem_addr), 32'h05);
    chk("ws_ack",   32'(imem_ack),  32'd1);
    step;
    chk("ws_newaddr", 32'(imem_addr), 32'h40);
    lat = 0;
    exp_q.push_back({8'h41, 16'h40BF});
    step;
    ack_en = 1'b0;
    wait_empty("ws_drain");

    // Redirect coinciding with the ack at 8'h10.
    lat = 0; ack_en = 1'b1; seg_ready = 1'b0;
    do_reset(1'b1, 8'h0F);
    step;
    redirect = 1'b0;
    step;
    chk("ra_vld0", 32'(seg_valid), 32'd1);
    chk("ra_addr", 32'(imem_addr), 32'h10);
    redirect = 1'b1; redirect_pc = 8'h80;
    step;
    redirect = 1'b0;
    chk("ra_vld1",  32'(seg_valid), 32'd0);
    chk("ra_addr1", 32'(imem_addr), 32'h80);
    chk("ra_req1",  32'(imem_req),  32'd1);
    seg_ready = 1'b1;
    exp_q.push_back({8'h81, 16'h807F});
    step;
    ack_en = 1'b0;
    wait_empty("ra_drain");

    // Wrap-around of fetch address and npc.
    lat = 0; ack_en = 1'b1; seg_ready = 1'b1;
    do_reset(1'b1, 8'hFE);
    exp_q.push_back({8'hFF, 16'hFE01});
    exp_q.push_back({8'h00, 16'hFF00});
    exp_q.push_back({8'h01, 16'h00FF});
    step;
    redirect = 1'b0;
    chk("wr_addr0", 32'(imem_addr), 32'hFE);
    step;
    step;
    chk("wr_addr2", 32'(imem_addr), 32'h00);
    step;
    chk("wr_addr3", 32'(imem_addr), 32'h01);
    ack_en = 1'b0;
    wait_empty("wr_drain");

    // Asynchronous reset in the middle of a pending request.
    lat = 0; ack_en = 1'b1; seg_ready = 1'b0;
    do_reset(1'b0, 8'h00);
    step;
    step;
    ack_en = 1'b0;
    chk("ar_vld0",  32'(seg_valid), 32'd1);
    chk("ar_addr0", 32'(imem_addr), 32'h01);
    step;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req",  32'(imem_req),  32'd0);
    chk("ar_vld",  32'(seg_valid), 32'd0);
    chk("ar_addr", 32'(imem_addr), 32'h00);
    chk("ar_seg",  32'(segment),   32'h0000);
    chk("ar_npc",  32'(npc),       32'h00);
    step;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
